smaesh_svrs_scheduler: RTL and testbench

Parametrised stream scheduler that arbitrates data, reseed and rekey requests in front of the masked 32-bit AES core, the key storage unit and the PRNG. It merges NCH shared-plaintext channels by round-robin, tags every accepted block so ciphertexts can be routed back, and enforces an optional automatic reseed after a programmable number of blocks. It replaces the fixed single-channel glue logic of the encryption top level.

---
 rtl/smaesh_svrs_scheduler.sv | 130 +++++++++++++
 tb/tb_smaesh_svrs_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/smaesh_svrs_scheduler.sv
// Request scheduler in front of the masked AES core: round-robin merge of NCH
// plaintext channels, in-flight tag FIFO for ciphertext routing, auto-reseed budget.
module smaesh_svrs_scheduler #(
  parameter int d         = 2,
  parameter int NCH       = 2,
  parameter int TAGW      = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int TAG_DEPTH = 2,
  parameter int PW        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_data_valid,
  output logic [NCH-1:0]        in_data_ready,
  input  logic [NCH*128*d-1:0]  in_shares_data,
  input  logic                  in_key_valid,
  input  logic                  in_seed_valid,
  output logic                  in_seed_ready,
  input  logic [PW-1:0]         reseed_period,
  output logic                  reseed_required,
  input  logic                  prng_out_valid,
  input  logic                  prng_busy,
  output logic                  prng_start_reseed,
  input  logic                  ksu_busy,
  input  logic                  ksu_last_key_req,
  output logic                  ksu_start_fetch,
  input  logic                  core_busy,
  input  logic                  core_ready_in,
  output logic                  core_valid_in,
  output logic                  core_key_schedule_only,
  output logic [128*d-1:0]      core_sh_plaintext,
  input  logic                  core_cipher_valid,
  output logic                  core_out_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAGW-1:0]       out_tag
);
  // All handshakes are valid/ready: a transfer happens in any cycle where both are
  // high at the rising edge; outputs are combinational from inputs and state.
  localparam int BW = 128 * d;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic [TAGW-1:0] r_ptr;
  logic [PW-1:0]   r_cnt;
  logic            r_prev_prng_busy;
  logic [TAGW-1:0] r_tag_mem [TAG_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [TAGW-1:0] w_gnt;
  logic            w_found;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_data_ok;
  logic            w_lk_run;
  logic            w_any_data;
  logic            w_push;
  logic            w_pop;

  // Cyclic search starting just after the last served channel.
  always_comb begin
    w_gnt   = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NCH;
      if (!w_found && in_data_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = TAGW'(idx);
      end
    end
  end

  assign w_fifo_full  = (r_count == CW'(TAG_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  assign reseed_required = (reseed_period != '0) && (r_cnt >= reseed_period);
  assign w_data_ok = ~ksu_busy & ~ksu_last_key_req & ~reseed_required &
                     prng_out_valid & ~w_fifo_full;
  assign w_lk_run  = ksu_last_key_req & ~core_busy & prng_out_valid & ~w_fifo_full;

  always_comb begin
    in_data_ready = '0;
    if (w_found && core_ready_in && w_data_ok) in_data_ready[w_gnt] = 1'b1;
  end

  assign core_sh_plaintext      = in_shares_data[int'(w_gnt)*BW +: BW];
  assign core_valid_in          = w_lk_run | (w_found & w_data_ok);
  assign core_key_schedule_only = w_lk_run;
  assign w_push                 = w_found & w_data_ok & core_ready_in;

  assign w_any_data = w_found & ~reseed_required;
  // A pending reseed outranks rekey, so in_key_valid cannot stall it.
  assign prng_start_reseed = in_seed_valid & ~w_any_data & ~core_busy & ~ksu_busy &
                             (~in_key_valid | reseed_required);
  assign ksu_start_fetch   = in_key_valid & ~w_any_data & ~core_busy & ~prng_busy &
                             ~in_seed_valid & ~reseed_required;
  assign in_seed_ready     = prng_busy & ~r_prev_prng_busy;

  // Ciphertexts arriving with no tag are last-key results and are swallowed.
  assign out_valid      = core_cipher_valid & ~w_fifo_empty;
  assign core_out_ready = (out_ready & ~w_fifo_empty) | (core_cipher_valid & w_fifo_empty);
  assign out_tag        = r_tag_mem[r_rd_ptr];
  assign w_pop          = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr            <= TAGW'(NCH - 1);
      r_cnt            <= '0;
      r_prev_prng_busy <= 1'b0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag_mem[i] <= '0;
    end else begin
      r_prev_prng_busy <= prng_busy;
      if (in_seed_ready) r_cnt <= '0;
      else if (w_push && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_push) begin
        r_ptr               <= w_gnt;
        r_tag_mem[r_wr_ptr] <= w_gnt;
        r_wr_ptr <= (r_wr_ptr == AW'(TAG_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == AW'(TAG_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_smaesh_svrs_scheduler.sv
// Directed self-checking bench for smaesh_svrs_scheduler: a 4-channel instance for
// arbitration/reseed/rekey/FIFO and a 4-bit-counter instance for saturation.
module tb_smaesh_svrs_scheduler;
  localparam int D = 2;
  localparam int NCH = 4;
  localparam int TAGW = 2;
  localparam int BW = 128 * D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]      in_data_valid, in_data_ready;
  logic [NCH*BW-1:0]   in_shares_data;
  logic                in_key_valid, in_seed_valid, in_seed_ready;
  logic [15:0]         reseed_period;
  logic                reseed_required, prng_out_valid, prng_busy, prng_start_reseed;
  logic                ksu_busy, ksu_last_key_req, ksu_start_fetch;
  logic                core_busy, core_ready_in, core_valid_in, core_key_schedule_only;
  logic [BW-1:0]       core_sh_plaintext;
  logic                core_cipher_valid, core_out_ready, out_valid, out_ready;
  logic [TAGW-1:0]     out_tag;

  smaesh_svrs_scheduler #(.d(D), .NCH(NCH), .TAGW(TAGW), .TAG_DEPTH(2), .PW(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_data_valid(in_data_valid), .in_data_ready(in_data_ready),
    .in_shares_data(in_shares_data), .in_key_valid(in_key_valid),
    .in_seed_valid(in_seed_valid), .in_seed_ready(in_seed_ready),
    .reseed_period(reseed_period), .reseed_required(reseed_required),
    .prng_out_valid(prng_out_valid), .prng_busy(prng_busy),
    .prng_start_reseed(prng_start_reseed), .ksu_busy(ksu_busy),
    .ksu_last_key_req(ksu_last_key_req), .ksu_start_fetch(ksu_start_fetch),
    .core_busy(core_busy), .core_ready_in(core_ready_in),
    .core_valid_in(core_valid_in), .core_key_schedule_only(core_key_schedule_only),
    .core_sh_plaintext(core_sh_plaintext), .core_cipher_valid(core_cipher_valid),
    .core_out_ready(core_out_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag)
  );

  // Small-counter instance: single channel, 4-bit block counter.
  logic [0:0]  s_data_valid, s_data_ready;
  logic [BW-1:0] s_shares, s_plaintext;
  logic [3:0]  s_period;
  logic        s_seed_ready, s_reseed_required, s_start_reseed, s_start_fetch;
  logic        s_core_valid, s_ks_only, s_core_out_ready, s_out_valid;
  logic [0:0]  s_out_tag;

  smaesh_svrs_scheduler #(.d(D), .NCH(1), .TAGW(1), .TAG_DEPTH(2), .PW(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_data_valid(s_data_valid), .in_data_ready(s_data_ready),
    .in_shares_data(s_shares), .in_key_valid(1'b0),
    .in_seed_valid(1'b0), .in_seed_ready(s_seed_ready),
    .reseed_period(s_period), .reseed_required(s_reseed_required),
    .prng_out_valid(1'b1), .prng_busy(1'b0),
    .prng_start_reseed(s_start_reseed), .ksu_busy(1'b0),
    .ksu_last_key_req(1'b0), .ksu_start_fetch(s_start_fetch),
    .core_busy(1'b0), .core_ready_in(1'b1),
    .core_valid_in(s_core_valid), .core_key_schedule_only(s_ks_only),
    .core_sh_plaintext(s_plaintext), .core_cipher_valid(1'b1),
    .core_out_ready(s_core_out_ready), .out_valid(s_out_valid),
    .out_ready(1'b1), .out_tag(s_out_tag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int g_seq [3] = '{0, 2, 3};
  int prev_g;
  logic [31:0] word;

  initial begin
    rst = 1'b1;
    in_data_valid = '0; in_key_valid = 0; in_seed_valid = 0; reseed_period = '0;
    prng_out_valid = 0; prng_busy = 0; ksu_busy = 0; ksu_last_key_req = 0;
    core_busy = 0; core_ready_in = 0; core_cipher_valid = 0; out_ready = 0;
    s_data_valid = '0; s_period = '0; s_shares = '0;
    for (int i = 0; i < NCH; i++) in_shares_data[i*BW +: BW] = {8{32'hA5A50000 + i}};
    tick(); tick();
    #1;
    chk("rst_data_ready", 32'(in_data_ready), 0);
    chk("rst_core_valid", 32'(core_valid_in), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_reseed_req", 32'(reseed_required), 0);
    chk("rst_seed_ready", 32'(in_seed_ready), 0);
    chk("rst_core_out_ready", 32'(core_out_ready), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    rst = 1'b0;

    // Round robin over channels 0,2,3; tags emerge one cycle after their grant.
    prng_out_valid = 1; core_ready_in = 1; out_ready = 1; core_cipher_valid = 1;
    in_data_valid = 4'b1101;
    prev_g = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(in_data_ready), 32'(1) << g_seq[k % 3]);
      word = core_sh_plaintext[31:0];
      chk("rr_plaintext", word, 32'hA5A50000 + 32'(g_seq[k % 3]));
      if (k > 0) begin
        chk("rr_out_valid", 32'(out_valid), 1);
        chk("rr_out_tag", 32'(out_tag), 32'(prev_g));
      end
      prev_g = g_seq[k % 3];
      tick();
    end
    in_data_valid = '0;
    #1;
    chk("rr_last_tag", 32'(out_tag), 3);
    tick();
    chk("swallow_out_valid", 32'(out_valid), 0);
    chk("swallow_out_ready", 32'(core_out_ready), 1);

    // Lowering the period below the count (6) blocks data immediately.
    reseed_period = 16'd3;
    in_data_valid = 4'b0001;
    #1;
    chk("rs_required_now", 32'(reseed_required), 1);
    chk("rs_ready_blocked", 32'(in_data_ready), 0);
    chk("rs_core_valid_blocked", 32'(core_valid_in), 0);
    in_seed_valid = 1;
    #1;
    chk("rs_start_reseed", 32'(prng_start_reseed), 1);
    tick();
    prng_busy = 1;
    #1;
    chk("rs_seed_ready_pulse", 32'(in_seed_ready), 1);
    tick();
    in_seed_valid = 0;
    #1;
    chk("rs_seed_ready_drop", 32'(in_seed_ready), 0);
    chk("rs_required_clear", 32'(reseed_required), 0);
    prng_busy = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rs_accept", 32'(in_data_ready), 1);
      tick();
    end
    chk("rs_required_after3", 32'(reseed_required), 1);
    chk("rs_ready_after3", 32'(in_data_ready), 0);
    in_key_valid = 1; in_seed_valid = 1;
    #1;
    chk("rs_key_ignored", 32'(prng_start_reseed), 1);
    chk("rs_no_fetch", 32'(ksu_start_fetch), 0);
    in_seed_valid = 0; reseed_period = 16'd0;
    #1;
    chk("rs_period0_disable", 32'(reseed_required), 0);
    in_key_valid = 0; in_data_valid = '0;
    tick();

    // Rekey waits for data to drain and the core to go idle.
    in_key_valid = 1; in_data_valid = 4'b0010;
    #1;
    chk("key_fetch_blocked", 32'(ksu_start_fetch), 0);
    chk("key_data_first", 32'(in_data_ready), 32'b0010);
    tick();
    in_data_valid = '0; core_busy = 1;
    #1;
    chk("key_busy_blocked", 32'(ksu_start_fetch), 0);
    chk("key_tag", 32'(out_tag), 1);
    chk("key_out_valid", 32'(out_valid), 1);
    tick();
    core_busy = 0;
    #1;
    chk("key_fetch", 32'(ksu_start_fetch), 1);
    in_key_valid = 0;

    // Last-key run outranks data and pushes no tag.
    core_cipher_valid = 0; ksu_last_key_req = 1; in_data_valid = 4'b0001;
    #1;
    chk("lk_core_valid", 32'(core_valid_in), 1);
    chk("lk_ks_only", 32'(core_key_schedule_only), 1);
    chk("lk_no_data", 32'(in_data_ready), 0);
    tick();
    ksu_last_key_req = 0; in_data_valid = '0; core_cipher_valid = 1;
    #1;
    chk("lk_swallow_valid", 32'(out_valid), 0);
    chk("lk_swallow_ready", 32'(core_out_ready), 1);
    chk("lk_ks_only_off", 32'(core_key_schedule_only), 0);
    tick();

    // Tag FIFO fills at depth 2 and frees one slot per transfer.
    out_ready = 0; core_cipher_valid = 0; in_data_valid = 4'b1000;
    #1;
    chk("ff_accept1", 32'(in_data_ready), 32'b1000);
    tick();
    chk("ff_accept2", 32'(in_data_ready), 32'b1000);
    tick();
    chk("ff_full_ready", 32'(in_data_ready), 0);
    chk("ff_full_core_valid", 32'(core_valid_in), 0);
    out_ready = 1; core_cipher_valid = 1;
    #1;
    chk("ff_pop_valid", 32'(out_valid), 1);
    chk("ff_pop_tag", 32'(out_tag), 3);
    chk("ff_pop_still_full", 32'(in_data_ready), 0);
    tick();
    out_ready = 0; core_cipher_valid = 0;
    #1;
    chk("ff_one_more", 32'(in_data_ready), 32'b1000);
    tick();
    chk("ff_full_again", 32'(in_data_ready), 0);
    rst = 1;
    tick();
    rst = 0;
    in_data_valid = 4'b1001; core_cipher_valid = 1;
    #1;
    chk("mrst_empty", 32'(out_valid), 0);
    chk("mrst_swallow", 32'(core_out_ready), 1);
    chk("mrst_ptr", 32'(in_data_ready), 32'b0001);
    in_data_valid = '0; core_cipher_valid = 0;

    // 20 blocks with auto-reseed disabled: the 4-bit counter must stick at 15.
    s_data_valid = 1'b1; s_period = 4'd0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("sat_ready", 32'(s_data_ready), 1);
      chk("sat_no_required", 32'(s_reseed_required), 0);
      tick();
    end
    s_period = 4'd15;
    #1;
    chk("sat_at_max", 32'(s_reseed_required), 1);
    chk("sat_blocked", 32'(s_data_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
